// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared opcode, funct and ALU encodings for the decode stage
package mips_defs;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  // IF/ID contents after reset or squash; this word decodes as a side-effect-free NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read 1-write register file with r0 hardwired and write bypass
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [XLEN-1:0]          ra_data,
  output logic [XLEN-1:0]          rb_data,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: cleared on reset, writes to r0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read ports: r0 is always zero, a same-cycle write to the read index is forwarded
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr != '0) ra_data = (wb_en && (wb_addr == ra_addr)) ? wb_data : regs[ra_addr];
    if (rb_addr != '0) rb_data = (wb_en && (wb_addr == rb_addr)) ? wb_data : regs[rb_addr];
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - IF/ID register, register file, main decoder and branch resolution
module id_stage
  import mips_defs::*;
#(
  parameter int          XLEN      = mips_defs::XLEN,
  parameter int          NREGS     = mips_defs::NREGS,
  parameter logic [31:0] NOP_WORD  = mips_defs::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              if_instr,
  input  logic                     if_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     id_valid,
  output logic [XLEN-1:0]          rs_data,
  output logic [XLEN-1:0]          rt_data,
  output logic [XLEN-1:0]          imm_ext,
  output logic [$clog2(NREGS)-1:0] dst_reg,
  output logic                     reg_write,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     mem_to_reg,
  output logic                     alu_src,
  output logic [2:0]               alu_op,
  output logic                     illegal,
  output logic                     is_branch,
  output logic                     is_jump,
  output logic [15:0]              imm16,
  output logic [25:0]              addr26
);

  logic [31:0] instr_q;
  logic        valid_q;
  logic        redirect;

  logic        dec_rw, dec_mr, dec_mw, dec_m2r, dec_as, dec_ill;
  logic        dec_beq, dec_bne, dec_j;
  alu_op_t     dec_alu;
  logic [$clog2(NREGS)-1:0] dec_dst;

  // IF/ID register: flush beats stall, stall beats the redirect squash, else load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (!stall) begin
      if (redirect) begin
        valid_q <= 1'b0;
      end else begin
        instr_q <= if_instr;
        valid_q <= if_valid;
      end
    end
  end

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (instr_q[25:21]),
    .rb_addr (instr_q[20:16]),
    .ra_data (rs_data),
    .rb_data (rt_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // Main decoder: NOP word has no effect, unknown encodings raise illegal with no control
  always_comb begin
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_m2r = 1'b0;
    dec_as  = 1'b0;
    dec_ill = 1'b0;
    dec_beq = 1'b0;
    dec_bne = 1'b0;
    dec_j   = 1'b0;
    dec_alu = ALU_ADD;
    dec_dst = '0;
    if (instr_q != NOP_WORD) begin
      case (instr_q[31:26])
        OP_RTYPE: begin
          dec_rw  = 1'b1;
          dec_dst = instr_q[15:11];
          case (instr_q[5:0])
            FN_ADD:  dec_alu = ALU_ADD;
            FN_SUB:  dec_alu = ALU_SUB;
            FN_AND:  dec_alu = ALU_AND;
            FN_OR:   dec_alu = ALU_OR;
            FN_SLT:  dec_alu = ALU_SLT;
            default: begin
              dec_ill = 1'b1;
              dec_rw  = 1'b0;
              dec_dst = '0;
            end
          endcase
        end
        OP_ADDI: begin
          dec_rw  = 1'b1;
          dec_as  = 1'b1;
          dec_dst = instr_q[20:16];
        end
        OP_LW: begin
          dec_rw  = 1'b1;
          dec_mr  = 1'b1;
          dec_m2r = 1'b1;
          dec_as  = 1'b1;
          dec_dst = instr_q[20:16];
        end
        OP_SW: begin
          dec_mw = 1'b1;
          dec_as = 1'b1;
        end
        OP_BEQ: begin
          dec_beq = 1'b1;
          dec_alu = ALU_SUB;
        end
        OP_BNE: begin
          dec_bne = 1'b1;
          dec_alu = ALU_SUB;
        end
        OP_J:    dec_j   = 1'b1;
        default: dec_ill = 1'b1;
      endcase
    end
  end

  // Output gating and branch resolution on the bypassed operands; stall holds off redirects
  always_comb begin
    id_valid   = valid_q;
    reg_write  = valid_q & dec_rw;
    mem_read   = valid_q & dec_mr;
    mem_write  = valid_q & dec_mw;
    mem_to_reg = valid_q & dec_m2r;
    illegal    = valid_q & dec_ill;
    alu_src    = dec_as;
    alu_op     = dec_alu;
    dst_reg    = dec_dst;
    is_branch  = valid_q & ~stall &
                 ((dec_beq & (rs_data == rt_data)) | (dec_bne & (rs_data != rt_data)));
    is_jump    = valid_q & ~stall & dec_j;
    redirect   = is_branch | is_jump;
    imm_ext    = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
    imm16      = instr_q[15:0];
    addr26     = instr_q[25:0];
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage against a mnemonic-level model
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_instr;
  logic        if_valid, stall, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
  logic        illegal, is_branch, is_jump;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [4:0]  dst_reg;
  logic [2:0]  alu_op;
  logic [15:0] imm16;
  logic [25:0] addr26;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_valid(if_valid),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .dst_reg(dst_reg), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal),
    .is_branch(is_branch), .is_jump(is_jump), .imm16(imm16), .addr26(addr26)
  );

  // ---------------- model ----------------
  typedef enum {K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_LW, K_SW,
                K_BEQ, K_BNE, K_J, K_BAD} kind_t;

  typedef struct packed {
    logic        v, rw, mr, mw, m2r, as, ill, br, j;
    logic [2:0]  op;
    logic [4:0]  dst;
    logic [31:0] rs, rt, imm;
    logic [15:0] i16;
    logic [25:0] a26;
  } exp_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_instr;
  logic        m_valid;

  function automatic kind_t classify(input logic [31:0] w);
    if (w == 32'h0) return K_NOP;
    case (w[31:26])
      6'd0: case (w[5:0])
              6'd32: return K_ADD;
              6'd34: return K_SUB;
              6'd36: return K_AND;
              6'd37: return K_OR;
              6'd42: return K_SLT;
              default: return K_BAD;
            endcase
      6'd8:  return K_ADDI;
      6'd35: return K_LW;
      6'd43: return K_SW;
      6'd4:  return K_BEQ;
      6'd5:  return K_BNE;
      6'd2:  return K_J;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic exp_t model();
    exp_t  e;
    kind_t k;
    e = '0;
    k = classify(m_instr);
    e.rs  = m_read(m_instr[25:21]);
    e.rt  = m_read(m_instr[20:16]);
    e.imm = {{16{m_instr[15]}}, m_instr[15:0]};
    e.i16 = m_instr[15:0];
    e.a26 = m_instr[25:0];
    e.v   = m_valid;
    case (k)
      K_ADD: begin e.rw = 1; e.dst = m_instr[15:11]; e.op = 3'd0; end
      K_SUB: begin e.rw = 1; e.dst = m_instr[15:11]; e.op = 3'd1; end
      K_AND: begin e.rw = 1; e.dst = m_instr[15:11]; e.op = 3'd2; end
      K_OR:  begin e.rw = 1; e.dst = m_instr[15:11]; e.op = 3'd3; end
      K_SLT: begin e.rw = 1; e.dst = m_instr[15:11]; e.op = 3'd4; end
      K_ADDI: begin e.rw = 1; e.as = 1; e.dst = m_instr[20:16]; end
      K_LW:  begin e.rw = 1; e.mr = 1; e.m2r = 1; e.as = 1; e.dst = m_instr[20:16]; end
      K_SW:  begin e.mw = 1; e.as = 1; end
      K_BEQ: begin e.op = 3'd1; e.br = (e.rs == e.rt); end
      K_BNE: begin e.op = 3'd1; e.br = (e.rs != e.rt); end
      K_J:   e.j = 1;
      K_BAD: e.ill = 1;
      default: ;
    endcase
    if (!m_valid) begin
      e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.ill = 0; e.br = 0; e.j = 0;
    end
    if (stall) begin
      e.br = 0; e.j = 0;
    end
    return e;
  endfunction

  // model state advance, using the same clock/reset events as the design
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else begin
      e = model();
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (flush) begin
        m_instr = 32'h0;
        m_valid = 1'b0;
      end else if (stall) begin
        m_instr = m_instr;
      end else if (e.br || e.j) begin
        m_valid = 1'b0;
      end else begin
        m_instr = if_instr;
        m_valid = if_valid;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    exp_t e;
    e = model();
    chk("id_valid", 32'(id_valid), 32'(e.v));
    chk("rs_data", rs_data, e.rs);
    chk("rt_data", rt_data, e.rt);
    chk("imm_ext", imm_ext, e.imm);
    chk("dst_reg", 32'(dst_reg), 32'(e.dst));
    chk("reg_write", 32'(reg_write), 32'(e.rw));
    chk("mem_read", 32'(mem_read), 32'(e.mr));
    chk("mem_write", 32'(mem_write), 32'(e.mw));
    chk("mem_to_reg", 32'(mem_to_reg), 32'(e.m2r));
    chk("alu_src", 32'(alu_src), 32'(e.as));
    chk("alu_op", 32'(alu_op), 32'(e.op));
    chk("illegal", 32'(illegal), 32'(e.ill));
    chk("is_branch", 32'(is_branch), 32'(e.br));
    chk("is_jump", 32'(is_jump), 32'(e.j));
    chk("imm16", 32'(imm16), 32'(e.i16));
    chk("addr26", 32'(addr26), 32'(e.a26));
  end

  // ---------------- stimulus ----------------
  // Inputs set here are live for this cycle (stall/wb) and loaded at its closing edge
  task automatic cyc(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    if_instr = ins; if_valid = v; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] ins);
    cyc(ins, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  localparam logic [31:0] ADDI48  = 32'h2004_0008;
  localparam logic [31:0] BEQ45   = 32'h1085_0003;
  localparam logic [31:0] BEQ05   = 32'h1005_0003;
  localparam logic [31:0] J2      = 32'h0800_0002;
  localparam logic [31:0] BNE40   = 32'h1480_0004;
  localparam logic [31:0] BADOP   = 32'hFC00_0000;
  localparam logic [31:0] ADD645  = 32'h0085_3020;
  localparam logic [31:0] AND745  = 32'h0085_3824;
  localparam logic [31:0] SLT845  = 32'h0085_402A;
  localparam logic [31:0] LW94    = 32'h8C89_0004;
  localparam logic [31:0] SW94    = 32'hAC89_0004;

  initial begin
    rst_n = 1'b0;
    if_instr = 32'h0; if_valid = 0; stall = 0; flush = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;

    // reset held three cycles while the ifu drives garbage
    repeat (3) cyc(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_rs", rs_data, 0);
    chk("rst_rt", rt_data, 0);
    chk("rst_redirect", 32'(is_branch | is_jump), 0);
    rst_n = 1'b1;

    // addi $4,$0,8
    load(ADDI48);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("addi_reg_write", 32'(reg_write), 1);
    chk("addi_alu_src", 32'(alu_src), 1);
    chk("addi_dst", 32'(dst_reg), 4);
    chk("addi_imm", imm_ext, 32'h8);
    chk("addi_alu_op", 32'(alu_op), 0);

    // beq $4,$5 with r5=5 and r4 forwarded from the same-cycle write
    cyc(BEQ45, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'd5);
    cyc(ADDI48, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'd5);
    chk("bypass_branch", 32'(is_branch), 1);
    cyc(BEQ05, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("branch_squash", 32'(id_valid), 0);
    // beq $0,$5 with a write aimed at r0
    cyc(J2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd5);
    chk("r0_rs", rs_data, 0);
    chk("r0_branch", 32'(is_branch), 0);

    // jump then addi: the addi is squashed
    load(ADDI48);
    chk("jump", 32'(is_jump), 1);
    chk("jump_addr26", 32'(addr26), 2);
    load(BNE40);
    chk("jump_squash_valid", 32'(id_valid), 0);
    chk("jump_squash_rw", 32'(reg_write), 0);

    // bne $4,$0 taken, held by two stall cycles
    cyc(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("stall1_branch", 32'(is_branch), 0);
    cyc(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("stall2_branch", 32'(is_branch), 0);
    chk("stall2_valid", 32'(id_valid), 1);
    load(ADDI48);
    chk("release_branch", 32'(is_branch), 1);
    load(ADDI48);
    cyc(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("pre_flush_valid", 32'(id_valid), 1);
    load(BADOP);
    chk("flush_valid", 32'(id_valid), 0);

    // unsupported opcode
    load(32'h0);
    chk("illegal", 32'(illegal), 1);
    chk("illegal_rw", 32'(reg_write), 0);
    chk("illegal_mr", 32'(mem_read), 0);

    // asynchronous reset pulse mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(id_valid), 0);
    chk("async_illegal", 32'(illegal), 0);
    chk("async_imm16", 32'(imm16), 0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;

    // clean restart with zeroed registers, then a spread of encodings
    load(ADD645);
    load(AND745);
    chk("add_rs_zeroed", rs_data, 0);
    chk("add_rt_zeroed", rt_data, 0);
    chk("add_dst", 32'(dst_reg), 6);
    load(SLT845);
    chk("and_alu_op", 32'(alu_op), 2);
    load(LW94);
    chk("slt_alu_op", 32'(alu_op), 4);
    load(SW94);
    chk("lw_mem_read", 32'(mem_read), 1);
    chk("lw_dst", 32'(dst_reg), 9);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("sw_mem_write", 32'(mem_write), 1);
    chk("sw_rw", 32'(reg_write), 0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
